// File: rtl/seg7_pkg.sv
// Shared definitions for the decimal-readout adder: segment codes, FSM states
// and the decimal digit-count helper used to size-check the display.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

   // {g,f,e,d,c,b,a}, active-low; non-decimal nibbles render blank
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // decimal digits needed to print 2^n - 1
   function automatic int dec_digits(input int n);
      longint unsigned v;
      int d;
      v = (64'd1 << n) - 64'd1;
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble, one input bit per cycle. done and bcd are valid in
// the cycle of the final step so the caller can capture on that same edge.
module bin2bcd_seq #(
   parameter int NBITS  = 9,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NBITS-1:0]      bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(NBITS + 1);

   logic [NBITS-1:0]            sr;
   logic [4*DIGITS-1:0]         acc;
   logic [4*DIGITS-1:0]         adj;
   logic [4*DIGITS+NBITS-1:0]   nxt;
   logic [CW-1:0]               cnt;
   logic                        run;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
   end

   assign nxt  = {adj, sr} << 1;
   assign bcd  = nxt[4*DIGITS+NBITS-1:NBITS];
   assign done = run && (cnt == CW'(NBITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         acc <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         sr  <= bin;
         acc <= '0;
         cnt <= '0;
         run <= 1'b1;
      end else if (run) begin
         acc <= bcd;
         sr  <= nxt[NBITS-1:0];
         if (done) begin
            cnt <= '0;
            run <= 1'b0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/adder_bcd_display.sv
// Registered adder with decimal readout on a scanned bank of active-low
// seven-segment digits; shows either the decimal sum or the carry-out.
module adder_bcd_display
   import seg7_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sel,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   sum_out,
   output logic               cout,
   output logic [6:0]         seg,
   output logic [DIGITS-1:0]  an
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < dec_digits(WIDTH + 1)) begin : g_digits_chk
      $error("DIGITS too small to show the full sum");
   end

   state_t                    state;
   logic [WIDTH-1:0]          a_r, b_r;
   logic                      sel_r;
   logic [WIDTH:0]            sum_w;
   logic                      cv_done;
   logic [4*DIGITS-1:0]       cv_bcd;
   logic [DIGITS-1:0][6:0]    disp, disp_ld;
   logic                      lit;
   logic [PW-1:0]             pres;
   logic [IW-1:0]             idx;

   assign sum_w = {1'b0, a_r} + {1'b0, b_r};

   bin2bcd_seq #(.NBITS(WIDTH + 1), .DIGITS(DIGITS)) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state == ADD),
      .bin   (sum_w),
      .done  (cv_done),
      .bcd   (cv_bcd)
   );

   // blank leading zeros, but digit 0 always lit so zero reads "0"
   always_comb begin
      disp_ld = {DIGITS{SEG_BLANK}};
      lit     = 1'b0;
      if (sel_r) begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            lit = lit | (cv_bcd[4*i +: 4] != 4'd0) | (i == 0);
            if (lit) disp_ld[i] = seg_code(cv_bcd[4*i +: 4]);
         end
      end else begin
         disp_ld[0] = seg_code({3'b000, cout});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         sel_r   <= 1'b0;
         sum_out <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         disp    <= {DIGITS{SEG_BLANK}};
      end else begin
         busy <= (state == ADD) || (state == SHIFT);
         done <= (state == DONE);
         case (state)
            IDLE: if (start) begin
               a_r   <= a;
               b_r   <= b;
               sel_r <= sel;
               state <= ADD;
            end
            ADD: begin
               {cout, sum_out} <= sum_w;
               state           <= SHIFT;
            end
            SHIFT: if (cv_done) begin
               disp  <= disp_ld;
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // free-running scan, independent of the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pres <= '0;
         idx  <= '0;
         seg  <= SEG_BLANK;
         an   <= ~DIGITS'(1);
      end else begin
         if (pres == PW'(SCAN_DIV - 1)) begin
            pres <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            pres <= pres + PW'(1);
         end
         seg <= disp[idx];
         an  <= ~(DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_adder_bcd_display.sv
// Scoreboard bench: stimulus pushes model results, a monitor checks each done
// pulse, the registered sum/carry and the scanned digit codes.
module tb_adder_bcd_display;

   localparam int W = 8;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] SEGTAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

   typedef struct packed {
      logic [7:0]       sum;
      logic             co;
      logic [3:0][6:0]  dig;
      logic [31:0]      cyc;
   } exp_t;

   logic        clk = 0, rst_n = 0, sel = 0, start = 0;
   logic [7:0]  a = 0, b = 0;
   logic        busy, done, cout;
   logic [7:0]  sum_out;
   logic [6:0]  seg;
   logic [3:0]  an;

   int   cyc = 0;
   int   n_pass = 0, n_tot = 0;
   exp_t q[$];

   adder_bcd_display #(.WIDTH(W), .DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .start(start),
      .busy(busy), .done(done), .sum_out(sum_out), .cout(cout), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, want);
   endtask

   function automatic exp_t model(input int av, input int bv, input bit s);
      exp_t e;
      int   sum, p;
      sum   = av + bv;
      e     = '0;
      e.sum = 8'(sum % 256);
      e.co  = (sum >= 256);
      p     = 1;
      for (int i = 0; i < 4; i++) begin
         if (!s) e.dig[i] = (i == 0) ? SEGTAB[e.co ? 1 : 0] : BLANK;
         else    e.dig[i] = (i == 0 || sum >= p) ? SEGTAB[(sum / p) % 10] : BLANK;
         p = p * 10;
      end
      return e;
   endfunction

   task automatic op(input int av, input int bv, input bit s, input bit push);
      int   c;
      exp_t e;
      @(negedge clk);
      a = 8'(av); b = 8'(bv); sel = s; start = 1;
      @(posedge clk); #1;
      c = cyc; start = 0;
      if (push) begin
         e = model(av, bv, s);
         e.cyc = c + W + 3;
         q.push_back(e);
      end
      a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
      @(posedge clk); #1;
      chk("busy_k1", busy, 1);
   endtask

   task automatic wait_done(input int settle);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("done_seen", seen, 1);
      repeat (settle) @(negedge clk);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [6:0] got [4];
      bit         seen [4];
      bit         pend, badan, found;
      logic [3:0] oh;
      pend = 0;
      forever begin
         if (!pend) begin
            @(negedge clk);
            if (!done) continue;
         end
         pend = 0;
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
            continue;
         end
         e = q.pop_front();
         chk("sum_out", sum_out, e.sum);
         chk("cout", cout, e.co);
         chk("done_latency", cyc, e.cyc);
         for (int i = 0; i < 4; i++) seen[i] = 0;
         badan = 0;
         for (int n = 0; n < 16; n++) begin
            if (n > 0) begin
               @(negedge clk);
               if (done) begin pend = 1; break; end
            end
            if (!rst_n) break;
            found = 0;
            for (int i = 0; i < 4; i++) begin
               oh = 4'b0001 << i;
               if (an == ~oh) begin got[i] = seg; seen[i] = 1; found = 1; end
            end
            if (!found) badan = 1;
         end
         chk("an_onehot", badan, 0);
         for (int i = 0; i < 4; i++)
            if (seen[i]) chk($sformatf("digit%0d", i), got[i], e.dig[i]);
      end
   end

   initial begin : stim
      logic [3:0] prev, oh, ea;
      int         last, nchg;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout, 0);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_an", an, 4'b1110);

      rst_n = 1;
      prev = an; last = -1; nchg = 0;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         if (an !== prev) begin
            nchg++;
            oh = 4'b0001 << (nchg % 4);
            ea = ~oh;
            chk("scan_an", an, ea);
            if (last >= 0) chk("scan_period", t - last, 4);
            last = t; prev = an;
         end
      end
      chk("scan_steps", nchg >= 4, 1);

      op(255, 255, 1, 1); wait_done(18);
      op(200, 100, 0, 1); wait_done(18);
      op(15, 1, 0, 1);    wait_done(18);

      // starts during SHIFT and DONE must be ignored; the one after DONE is taken
      op(1, 1, 1, 1);
      repeat (2) @(negedge clk);
      a = 9; b = 9; sel = 1; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (8) @(negedge clk);
      a = 9; b = 9; sel = 1; start = 1;
      @(posedge clk); #1 start = 0;
      op(9, 9, 1, 1); wait_done(18);

      op(0, 0, 1, 1); wait_done(18);

      op(50, 60, 1, 0);
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_seg", seg, 7'b1111111);
      chk("mid_rst_an", an, 4'b1110);
      chk("mid_rst_sum", sum_out, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      op(100, 23, 1, 1); wait_done(18);

      for (int r = 0; r < 12; r++) begin
         op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1);
         wait_done(18);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adder_bcd_display.md
# adder_bcd_display

Parametrised registered adder with decimal readout. Adds two WIDTH-bit operands on a start pulse and converts the sum to BCD with a sequential double-dabble. It then drives a time-multiplexed bank of DIGITS seven-segment digits, showing either the decimal sum or the carry-out. It is the board-level successor to the 4-bit single-digit sum/carry display and sits between the switch/button inputs and the seven-segment pins.

## Interface
- WIDTH, 8, operand width in bits.
- DIGITS, 4, number of seven-segment digits; must be ≥ decimal digit count of 2^(WIDTH+1)-1, else elaboration error.
- SCAN_DIV, 50000, clk cycles per digit in the display scan (≥2).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A, sampled on accepted start.
- b  in  WIDTH  operand B, sampled on accepted start.
- sel  in  1  sampled on accepted start; 1 = show decimal sum, 0 = show carry-out.
- start  in  1  request; accepted only in IDLE.
- busy  out  1  high in ADD and SHIFT.
- done  out  1  one-cycle pulse in DONE.
- sum_out  out  WIDTH  registered low WIDTH bits of a+b.
- cout  out  1  registered carry-out of a+b.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit enables, one-hot active-low.

## Operation
- FSM states: IDLE, ADD, SHIFT, DONE.
- IDLE → ADD: on start=1. Capture a, b and sel.
- ADD → SHIFT: after one cycle. {cout, sum_out} ← a+b, computed at WIDTH+1 bits with no truncation.
- SHIFT: runs for WIDTH+1 cycles.
  - Each cycle, first add 3 to every BCD nibble ≥5, then shift left one bit from the MSB of the (WIDTH+1)-bit sum.
  - The iteration counter wraps to 0 on exit.
- DONE → IDLE: after one cycle, with done=1.
  - On entry to DONE, the display register loads from the captured sel.
  - sel=1: BCD digits with leading-zero blanking; digit 0 is always lit, so a sum of 0 shows "0".
  - sel=0: digit 0 = cout (0 or 1); all other digits blank.
- start is ignored in ADD, SHIFT and DONE; no queuing.
- Operand or sel changes outside the capture edge have no effect.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Display scan:
  - A free-running prescaler counts 0..SCAN_DIV-1.
  - On terminal count, the digit index advances and wraps DIGITS-1 → 0.
  - an drives low only the current digit; seg shows that digit's code, or blank.
  - The scan runs regardless of FSM state.

## Timing
- Reset values:
  - FSM=IDLE; busy=0, done=0; sum_out=0, cout=0.
  - Display register all-blank; seg=1111111.
  - Prescaler=0; digit index=0, so an = all ones except bit 0 = 0.
- Latency: start sampled at edge k → busy=1 from edge k+1; done=1 for the cycle after edge k+WIDTH+3; busy=0 from that same edge.
- Next accepted start is at the earliest edge k+WIDTH+4 (in IDLE).
- seg/an reflect the new result from edge k+WIDTH+3, at the currently scanned digit.
- Reset asserted mid-operation: immediate, asynchronous return to reset values, with the display cleared. A start after release completes normally.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `seg7_pkg`:
  - segment code constants (0–9, blank);
  - FSM state typedef;
  - a function giving the decimal digit count of 2^(n)-1, used for the DIGITS check.
- Sub-module `bin2bcd_seq`:
  - parametrised by input width and digit count;
  - start/done handshake; one bit per cycle.
- Top owns: FSM, adder, display register, scan counter, segment decode.

## Test plan
Bench settings: WIDTH=8, DIGITS=4, SCAN_DIV=4.
- Reset: hold rst_n=0 → busy=0, done=0, sum_out=0, cout=0, seg=1111111, an=1110. Release: an steps 1101, 1011, 0111, 1110, one step every 4 clks.
- Decimal sum: a=255, b=255, sel=1, start at edge k → done pulse after edge k+11; sum_out=0xFE, cout=1.
  - Digits 0,1,2 show 0,1,5 (codes 1000000, 1111001, 0010010); digit 3 blank.
- Carry display: a=200, b=100, sel=0 → cout=1, sum_out=0x2C; digit 0 = 1111001, digits 1–3 blank.
  - Then a=15, b=1, sel=0 → digit 0 = 1000000.
- Start while busy: a=1, b=1, sel=1, start; reassert start with a=9, b=9 at edges k+3 and k+11 (DONE).
  - Single done; display "2" in digit 0 only.
  - A start at k+12 is accepted and shows "18".
- Zero sum: a=0, b=0, sel=1 → digit 0 = 1000000, digits 1–3 blank, cout=0.
- Mid-operation reset: rst_n=0 during SHIFT → busy=0 and the display blanks immediately.
  - After release, a=100, b=23, sel=1 → "123".
